// File: rtl/axis_pkt_packer.sv
// AXI-Stream sample packer: gathers PACK_RATIO narrow samples into one wide beat.
// A tlast on any lane flushes the partial word, with tkeep marking the lanes in use.
// Optional packet counter on pkt_count, enabled by defining AXIS_PKT_PACKER_STATS_EN.
module axis_pkt_packer #(
    parameter int unsigned TDATA_WIDTH = 8,
    parameter int unsigned PACK_RATIO  = 4
) (
    input  logic                              aclk,
    input  logic                              resetn,
    input  logic                              s_axis_tvalid,
    output logic                              s_axis_tready,
    input  logic [TDATA_WIDTH-1:0]            s_axis_tdata,
    input  logic                              s_axis_tlast,
    output logic                              m_axis_tvalid,
    input  logic                              m_axis_tready,
    output logic [TDATA_WIDTH*PACK_RATIO-1:0] m_axis_tdata,
    output logic [TDATA_WIDTH*PACK_RATIO/8-1:0] m_axis_tkeep,
    output logic                              m_axis_tlast,
    output logic [31:0]                       pkt_count
);

    localparam int unsigned OutW      = TDATA_WIDTH * PACK_RATIO;
    localparam int unsigned KeepW     = OutW / 8;
    localparam int unsigned LaneBytes = TDATA_WIDTH / 8;
    localparam int unsigned LaneW     = ($clog2(PACK_RATIO) > 0) ? $clog2(PACK_RATIO) : 1;
    localparam logic [LaneW-1:0] LastLane = LaneW'(PACK_RATIO - 1);

    logic [LaneW-1:0]                       lane_q, lane_d;
    logic [PACK_RATIO-2:0][TDATA_WIDTH-1:0] acc_q, acc_d;
    logic [OutW-1:0]                        data_q, data_d;
    logic [KeepW-1:0]                       keep_q, keep_d;
    logic                                   last_q, last_d;
    logic                                   valid_q, valid_d;

    logic             accept;
    logic             close;
    logic [OutW-1:0]  acc_ext;
    logic [OutW-1:0]  word;
    logic [KeepW-1:0] word_keep;

    // Output register may take a new word when empty or being drained this cycle.
    assign s_axis_tready = ~valid_q | m_axis_tready;
    assign accept        = s_axis_tvalid & s_axis_tready;
    assign close         = accept & ((lane_q == LastLane) | s_axis_tlast);
    // Top lane is never stored; pad it so every lane can be sliced uniformly.
    assign acc_ext       = {{TDATA_WIDTH{1'b0}}, acc_q};

    // Assemble the closing word: stored lanes below `lane`, live sample at `lane`, zeros above.
    always_comb begin
        word      = '0;
        word_keep = '0;
        for (int k = 0; k < PACK_RATIO; k++) begin
            if (LaneW'(k) < lane_q) begin
                word[k*TDATA_WIDTH +: TDATA_WIDTH] = acc_ext[k*TDATA_WIDTH +: TDATA_WIDTH];
            end else if (LaneW'(k) == lane_q) begin
                word[k*TDATA_WIDTH +: TDATA_WIDTH] = s_axis_tdata;
            end
            if (LaneW'(k) <= lane_q) begin
                word_keep[k*LaneBytes +: LaneBytes] = '1;
            end
        end
    end

    // Next-state: accumulate, close a word into the output register, or drain it.
    always_comb begin
        lane_d  = lane_q;
        acc_d   = acc_q;
        data_d  = data_q;
        keep_d  = keep_q;
        last_d  = last_q;
        valid_d = valid_q;
        if (close) begin
            lane_d  = '0;
            acc_d   = '0;
            data_d  = word;
            keep_d  = word_keep;
            last_d  = s_axis_tlast;
            valid_d = 1'b1;
        end else begin
            if (accept) begin
                lane_d = lane_q + 1'b1;
                for (int k = 0; k < PACK_RATIO - 1; k++) begin
                    if (LaneW'(k) == lane_q) begin
                        acc_d[k] = s_axis_tdata;
                    end
                end
            end
            if (valid_q & m_axis_tready) begin
                valid_d = 1'b0;
            end
        end
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge aclk) begin
        if (!resetn) begin
            lane_q  <= '0;
            acc_q   <= '0;
            data_q  <= '0;
            keep_q  <= '0;
            last_q  <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            lane_q  <= lane_d;
            acc_q   <= acc_d;
            data_q  <= data_d;
            keep_q  <= keep_d;
            last_q  <= last_d;
            valid_q <= valid_d;
        end
    end

    assign m_axis_tvalid = valid_q;
    assign m_axis_tdata  = data_q;
    assign m_axis_tkeep  = keep_q;
    assign m_axis_tlast  = last_q;

`ifdef AXIS_PKT_PACKER_STATS_EN
    logic [31:0] pkt_count_q;

    // Count packets as their last beat is handed downstream; wraps naturally.
    always_ff @(posedge aclk) begin
        if (!resetn) begin
            pkt_count_q <= '0;
        end else if (valid_q & m_axis_tready & last_q) begin
            pkt_count_q <= pkt_count_q + 32'd1;
        end
    end

    assign pkt_count = pkt_count_q;
`else
    assign pkt_count = '0;
`endif

endmodule

// File: tb/tb_axis_pkt_packer.sv
// Self-checking bench for axis_pkt_packer (TDATA_WIDTH=8, PACK_RATIO=4).
module tb_axis_pkt_packer;

    logic        aclk = 1'b0;
    logic        resetn = 1'b0;
    logic        s_valid = 1'b0;
    logic        s_ready;
    logic [7:0]  s_data = '0;
    logic        s_last = 1'b0;
    logic        m_valid;
    logic        m_ready = 1'b0;
    logic [31:0] m_data;
    logic [3:0]  m_keep;
    logic        m_last;
    logic [31:0] pkt_count;

    int checks = 0;
    int errors = 0;

    axis_pkt_packer #(
        .TDATA_WIDTH(8),
        .PACK_RATIO (4)
    ) dut (
        .aclk         (aclk),
        .resetn       (resetn),
        .s_axis_tvalid(s_valid),
        .s_axis_tready(s_ready),
        .s_axis_tdata (s_data),
        .s_axis_tlast (s_last),
        .m_axis_tvalid(m_valid),
        .m_axis_tready(m_ready),
        .m_axis_tdata (m_data),
        .m_axis_tkeep (m_keep),
        .m_axis_tlast (m_last),
        .pkt_count    (pkt_count)
    );

    always #5 aclk = ~aclk;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Present one sample and hold it until accepted; returns 1 time unit after the accepting edge.
    task automatic send(input logic [7:0] d, input logic l);
        int w = 0;
        @(negedge aclk);
        s_valid = 1'b1;
        s_data  = d;
        s_last  = l;
        #1;
        while (!s_ready && w < 200) begin
            @(negedge aclk);
            #1;
            w++;
        end
        if (!s_ready) begin
            checks++;
            errors++;
            $display("FAIL send_timeout: s_axis_tready=%0b, required 1 within 200 cycles", s_ready);
        end
        @(posedge aclk);
        #1;
        s_valid = 1'b0;
        s_last  = 1'b0;
    endtask

    task automatic apply_reset();
        @(negedge aclk);
        resetn  = 1'b0;
        s_valid = 1'b0;
        s_last  = 1'b0;
        repeat (2) @(posedge aclk);
        @(negedge aclk);
        resetn = 1'b1;
    endtask

    task automatic test_reset();
        m_ready = 1'b0;
        apply_reset();
        #1;
        checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %0b want 0", m_valid); end
        checks++; if (m_data !== 32'h0) begin errors++; $display("FAIL reset_data: got %h want 0", m_data); end
        checks++; if (m_keep !== 4'h0) begin errors++; $display("FAIL reset_keep: got %h want 0", m_keep); end
        checks++; if (m_last !== 1'b0) begin errors++; $display("FAIL reset_last: got %0b want 0", m_last); end
        checks++; if (pkt_count !== 32'h0) begin errors++; $display("FAIL reset_count: got %0d want 0", pkt_count); end
        checks++; if (s_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %0b want 1", s_ready); end
    endtask

    task automatic test_basic();
        m_ready = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            send(8'(i), i == 8);
            if (i == 4) begin
                checks++;
                if (m_valid !== 1'b1 || m_data !== 32'h04030201 || m_keep !== 4'hF || m_last !== 1'b0) begin
                    errors++;
                    $display("FAIL basic_word0: got v=%0b d=%h k=%h l=%0b want v=1 d=04030201 k=f l=0",
                             m_valid, m_data, m_keep, m_last);
                end
            end else if (i == 8) begin
                checks++;
                if (m_valid !== 1'b1 || m_data !== 32'h08070605 || m_keep !== 4'hF || m_last !== 1'b1) begin
                    errors++;
                    $display("FAIL basic_word1: got v=%0b d=%h k=%h l=%0b want v=1 d=08070605 k=f l=1",
                             m_valid, m_data, m_keep, m_last);
                end
            end else begin
                checks++;
                if (m_valid !== 1'b0) begin
                    errors++;
                    $display("FAIL basic_idle_%0d: m_axis_tvalid got %0b want 0", i, m_valid);
                end
            end
        end
        @(posedge aclk);
        #1;
        checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL basic_drain: got v=%0b want 0", m_valid); end
    endtask

    task automatic test_partial();
        m_ready = 1'b1;
        send(8'h11, 1'b0);
        send(8'h22, 1'b0);
        send(8'h33, 1'b1);
        checks++;
        if (m_valid !== 1'b1 || m_data !== 32'h00332211 || m_keep !== 4'h7 || m_last !== 1'b1) begin
            errors++;
            $display("FAIL partial3: got v=%0b d=%h k=%h l=%0b want v=1 d=00332211 k=7 l=1",
                     m_valid, m_data, m_keep, m_last);
        end
        send(8'hAA, 1'b1);
        checks++;
        if (m_valid !== 1'b1 || m_data !== 32'h000000AA || m_keep !== 4'h1 || m_last !== 1'b1) begin
            errors++;
            $display("FAIL single: got v=%0b d=%h k=%h l=%0b want v=1 d=000000aa k=1 l=1",
                     m_valid, m_data, m_keep, m_last);
        end
        @(posedge aclk);
        #1;
    endtask

    task automatic test_backpressure();
        m_ready = 1'b0;
        send(8'hC1, 1'b0);
        send(8'hC2, 1'b0);
        send(8'hC3, 1'b0);
        send(8'hC4, 1'b0);
        @(negedge aclk);
        s_valid = 1'b1;
        s_data  = 8'h55;
        for (int i = 0; i < 5; i++) begin
            #1;
            checks++;
            if (s_ready !== 1'b0 || m_valid !== 1'b1 || m_data !== 32'hC4C3C2C1 ||
                m_keep !== 4'hF || m_last !== 1'b0) begin
                errors++;
                $display("FAIL stall_%0d: got rdy=%0b v=%0b d=%h k=%h l=%0b want rdy=0 v=1 d=c4c3c2c1 k=f l=0",
                         i, s_ready, m_valid, m_data, m_keep, m_last);
            end
            @(negedge aclk);
        end
        m_ready = 1'b1;
        #1;
        checks++; if (s_ready !== 1'b1) begin errors++; $display("FAIL release_ready: got %0b want 1", s_ready); end
        @(posedge aclk);
        #1;
        s_valid = 1'b0;
        checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL release_drain: got v=%0b want 0", m_valid); end
        send(8'h66, 1'b0);
        send(8'h77, 1'b0);
        send(8'h88, 1'b1);
        checks++;
        if (m_valid !== 1'b1 || m_data !== 32'h88776655 || m_keep !== 4'hF || m_last !== 1'b1) begin
            errors++;
            $display("FAIL resume_word: got v=%0b d=%h k=%h l=%0b want v=1 d=88776655 k=f l=1",
                     m_valid, m_data, m_keep, m_last);
        end
        @(posedge aclk);
        #1;
    endtask

    task automatic test_reset_mid();
        m_ready = 1'b1;
        send(8'hB0, 1'b0);
        send(8'hB1, 1'b0);
        @(negedge aclk);
        resetn = 1'b0;
        @(posedge aclk);
        #1;
        checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL midreset_valid: got %0b want 0", m_valid); end
        @(negedge aclk);
        resetn = 1'b1;
        for (int i = 0; i < 4; i++) begin
            send(8'hA0 + 8'(i), 1'b0);
            if (i < 3) begin
                checks++;
                if (m_valid !== 1'b0) begin
                    errors++;
                    $display("FAIL midreset_early_%0d: m_axis_tvalid got %0b want 0", i, m_valid);
                end
            end
        end
        checks++;
        if (m_valid !== 1'b1 || m_data !== 32'hA3A2A1A0 || m_keep !== 4'hF || m_last !== 1'b0) begin
            errors++;
            $display("FAIL midreset_word: got v=%0b d=%h k=%h l=%0b want v=1 d=a3a2a1a0 k=f l=0",
                     m_valid, m_data, m_keep, m_last);
        end
        @(posedge aclk);
        #1;
    endtask

    task automatic test_random();
        logic [7:0]  in_d[$];
        bit          in_l[$];
        logic [31:0] exp_d[$];
        logic [3:0]  exp_k[$];
        bit          exp_l[$];
        logic [31:0] acc;
        int          n;
        int          n_exp;
        int          got;
        int          cyc;
        bit          stall;
        logic [31:0] hd;
        logic [3:0]  hk;
        logic        hl;
        logic [31:0] exp_count;

        // Reference packing: every 4 samples or a tlast closes a word.
        for (int p = 0; p < 1000; p++) begin
            int len = $urandom_range(1, 37);
            acc = '0;
            n = 0;
            for (int b = 0; b < len; b++) begin
                logic [7:0] d = 8'($urandom);
                bit l = (b == len - 1);
                in_d.push_back(d);
                in_l.push_back(l);
                acc = acc | (32'(d) << (8 * n));
                n++;
                if (n == 4 || l) begin
                    exp_d.push_back(acc);
                    exp_k.push_back(4'((1 << n) - 1));
                    exp_l.push_back(l);
                    acc = '0;
                    n = 0;
                end
            end
        end
        n_exp = exp_d.size();

        m_ready = 1'b0;
        apply_reset();
        got = 0;
        cyc = 0;
        stall = 1'b0;
        fork
            begin
                for (int i = 0; i < in_d.size(); i++) begin
                    if ($urandom_range(0, 4) == 0) @(negedge aclk);
                    send(in_d[i], in_l[i]);
                end
            end
            begin
                while (got < n_exp && cyc < 60000) begin
                    @(negedge aclk);
                    m_ready = ($urandom_range(0, 4) != 0);
                    #1;
                    cyc++;
                    if (stall) begin
                        checks++;
                        if (m_valid !== 1'b1 || m_data !== hd || m_keep !== hk || m_last !== hl) begin
                            errors++;
                            $display("FAIL rand_hold: got v=%0b d=%h k=%h l=%0b want v=1 d=%h k=%h l=%0b",
                                     m_valid, m_data, m_keep, m_last, hd, hk, hl);
                        end
                    end
                    if (m_valid === 1'b1 && m_ready) begin
                        checks++;
                        if (m_data !== exp_d[got] || m_keep !== exp_k[got] || m_last !== exp_l[got]) begin
                            errors++;
                            $display("FAIL rand_beat_%0d: got d=%h k=%h l=%0b want d=%h k=%h l=%0b",
                                     got, m_data, m_keep, m_last, exp_d[got], exp_k[got], exp_l[got]);
                        end
                        got++;
                        stall = 1'b0;
                    end else if (m_valid === 1'b1) begin
                        stall = 1'b1;
                        hd = m_data;
                        hk = m_keep;
                        hl = m_last;
                    end else begin
                        stall = 1'b0;
                    end
                end
                m_ready = 1'b1;
                checks++;
                if (got != n_exp) begin
                    errors++;
                    $display("FAIL rand_timeout: got %0d beats want %0d", got, n_exp);
                end
            end
        join
        repeat (2) @(posedge aclk);
        #1;
        checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL rand_extra: got v=%0b want 0", m_valid); end
`ifdef AXIS_PKT_PACKER_STATS_EN
        exp_count = 32'd1000;
`else
        exp_count = 32'd0;
`endif
        checks++;
        if (pkt_count !== exp_count) begin
            errors++;
            $display("FAIL pkt_count: got %0d want %0d", pkt_count, exp_count);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_partial();
        test_backpressure();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/axis_pkt_packer.md
Name: axis_pkt_packer

Overview:
- Sits directly downstream of the DMA controller's tlast generator and upstream of the DMA S2MM port.
- Packs PACK_RATIO narrow samples into one wide AXI-Stream word.
- Honours tlast: a partial word is flushed at packet end with tkeep marking the valid lanes.
- The DMA then sees full-width beats and correct packet boundaries.

Parameters:
- TDATA_WIDTH, 8, input sample width in bits; must be a multiple of 8.
- PACK_RATIO, 4, samples per output word; must be ≥2.

Ports:
- aclk  input  1  clock.
- resetn  input  1  reset. Synchronous, active-low.
- s_axis_tvalid  input  1  input sample valid.
- s_axis_tready  output  1  block can accept an input sample.
- s_axis_tdata  input  TDATA_WIDTH  input sample.
- s_axis_tlast  input  1  last sample of the packet.
- m_axis_tvalid  output  1  packed word valid.
- m_axis_tready  input  1  downstream accepts the word.
- m_axis_tdata  output  TDATA_WIDTH*PACK_RATIO  packed word.
- m_axis_tkeep  output  TDATA_WIDTH*PACK_RATIO/8  byte enables.
- m_axis_tlast  output  1  last word of the packet.
- pkt_count  output  32  count of completed output packets (see Optional Feature).

Behaviour:
- State:
  - lane counter `lane` (0..PACK_RATIO-1).
  - accumulator `acc` (PACK_RATIO-1 lanes).
  - output register holding data/keep/last/valid.
- Lane ordering: first sample of a word goes in bits [TDATA_WIDTH-1:0]; sample k goes in lane k.
- s_axis_tready = ~m_axis_tvalid | m_axis_tready. It is combinational, and there is no dependency on s_axis_tvalid.
- Accept (s_axis_tvalid & s_axis_tready) with lane < PACK_RATIO-1 and s_axis_tlast=0:
  - sample is written into acc lane `lane`;
  - lane <= lane+1;
  - output register unchanged.
- Accept with lane == PACK_RATIO-1, or with s_axis_tlast=1 (word close):
  - output data = acc lanes 0..lane-1 plus the sample in lane `lane`; higher lanes are forced to 0;
  - tkeep = all bytes of lanes 0..lane set, others 0;
  - tlast = s_axis_tlast;
  - m_axis_tvalid <= 1;
  - lane <= 0;
  - acc cleared to 0.
- Output handshake: m_axis_tvalid & m_axis_tready with no word close in the same cycle clears m_axis_tvalid. A word close in the same cycle reloads the register and m_axis_tvalid stays 1.
- While m_axis_tvalid=1 and m_axis_tready=0:
  - s_axis_tready=0;
  - output data, keep and last are held stable (AXI-Stream rule);
  - lane and acc hold.
- Latency: one cycle from the closing input beat to m_axis_tvalid.
- Throughput: one input sample per cycle when m_axis_tready is held 1.
- Single-sample packet: tlast on lane 0 gives tkeep with only lane 0 bytes set.
- A tlast on lane PACK_RATIO-1 closes a full word with tlast=1; no extra beat is produced.
- Reset values (resetn=0 at posedge aclk): lane=0, acc=0, m_axis_tvalid=0, m_axis_tdata=0, m_axis_tkeep=0, m_axis_tlast=0, pkt_count=0.
- Reset mid-packet discards the partial word and any un-accepted output word. The first sample after reset lands in lane 0.
- Widths: lane is $clog2(PACK_RATIO) bits, minimum 1.

Optional Feature:
- Macro: AXIS_PKT_PACKER_STATS_EN.
- Defined:
  - pkt_count increments by 1 on each output handshake with m_axis_tlast=1;
  - it wraps from 2^32-1 to 0;
  - it is cleared by reset.
- Not defined: pkt_count is tied to 0 and no counter logic is generated.

Test Plan:
- TDATA_WIDTH=8, PACK_RATIO=4, m_axis_tready=1, samples 0x01..0x08 with tlast on 0x08 -> two words: 0x04030201 (keep 0xF, last 0) then 0x08070605 (keep 0xF, last 1), each one cycle after its closing sample.
- Samples 0x11,0x22,0x33 with tlast on 0x33 -> one word 0x00332211, keep 0x7, last 1. A single sample 0xAA with tlast -> 0x000000AA, keep 0x1, last 1.
- Hold m_axis_tready=0 for 5 cycles after a full word -> s_axis_tready=0 and the output is stable throughout. On release, the word transfers and input resumes with no lost or duplicated samples (check against a scoreboard).
- Reset asserted after 2 samples of a packet -> m_axis_tvalid=0. The next 4 samples 0xA0..0xA3 produce 0xA3A2A1A0 with keep 0xF.
- Random tvalid/tready with back-pressure, 1000 packets of random length 1..37 -> output matches the reference packing model; tkeep and tlast are correct on every beat.
- With AXIS_PKT_PACKER_STATS_EN: after the previous test, pkt_count=1000. Without the macro: pkt_count stays 0.
